// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: BOOT/FETCH/EXEC/TRAP sequencer with PC select for seq/jr/branch/jump.
// Define PC_ALIGN_CHECK_EN to trap on misaligned targets; otherwise target bits [1:0] are forced to zero.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PC_s,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        align_err
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] br_off;
  logic [31:0] raw_pc;
  logic [31:0] next_pc;
  logic        misaligned;

  // Target selection is purely PC_s driven; the decoder resolves branch conditions.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    raw_pc   = pc_plus4;
    case (PC_s)
      2'b00:   raw_pc = pc_plus4;
      2'b01:   raw_pc = rs_data;
      2'b10:   raw_pc = pc_plus4 + br_off;
      default: raw_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    endcase
`ifdef PC_ALIGN_CHECK_EN
    next_pc    = raw_pc;
    misaligned = (raw_pc[1:0] != 2'b00);
`else
    next_pc    = {raw_pc[31:2], 2'b00};
    misaligned = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = EXEC;
      EXEC:    if (inst_ready) state_d = misaligned ? TRAP : FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  // Acks and ready pulses outside their owning state leave inst/pc untouched.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    if (state_q == FETCH && imem_ack) inst_d = imem_rdata;
    if (state_q == EXEC && inst_ready && !misaligned) pc_d = next_pc;
  end

  always_comb begin
    imem_req   = (state_q == FETCH);
    inst_valid = (state_q == EXEC);
    imem_addr  = pc_q;
    pc         = pc_q;
    inst       = inst_q;
`ifdef PC_ALIGN_CHECK_EN
    align_err  = (state_q == TRAP);
`else
    align_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected fetch addresses and instructions are queued
// when stimulus is driven and compared when the DUT requests/presents them.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PC_s;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        align_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] last_inst;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_s       (PC_s),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for a request, check it against the scoreboard, ack after wait_cyc cycles.
  task automatic fetch(input logic [31:0] data, input int unsigned wait_cyc);
    int unsigned t = 0;
    logic [31:0] e;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      chk("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    if (exp_addr_q.size() == 0) begin
      chk("sb_addr_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_addr_q.pop_front();
    chk("imem_addr", imem_addr, e);
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, e);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_inst_q.push_back(data);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("inst_valid_rise", 32'(inst_valid), 32'd1);
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("inst", inst, exp_inst_q.pop_front());
    last_inst = data;
  endtask

  task automatic execute(input logic [1:0] sel, input logic [31:0] rs, input logic [31:0] exp_next);
    PC_s       = sel;
    rs_data    = rs;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    PC_s       = 2'b11;
    rs_data    = 32'h5555_5555;
    chk("inst_valid_drop", 32'(inst_valid), 32'd0);
    chk("pc_next", pc, exp_next);
    chk("pc_plus4", pc_plus4, exp_next + 32'd4);
    exp_addr_q.push_back(exp_next);
  endtask

  initial begin
    rst_n      = 1'b0;
    PC_s       = 2'b00;
    rs_data    = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    inst_ready = 1'b0;
    last_inst  = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_align", 32'(align_err), 32'd0);
    rst_n = 1'b1;
    #1 chk("boot_req", 32'(imem_req), 32'd0);
    exp_addr_q.push_back(32'h0);

    // Sequential fetch, memory acks 2 cycles after req
    fetch(32'h1111_0000, 2);
    execute(2'b00, '0, 32'h4);
    fetch(32'h1111_0004, 2);
    execute(2'b00, '0, 32'h8);
    fetch(32'h1111_0008, 2);
    execute(2'b00, '0, 32'hC);
    fetch(32'h1111_000C, 2);

    // Branch backward / forward from 0x100, zero-wait ack on the first
    execute(2'b01, 32'h100, 32'h100);
    fetch(32'h0000_FFFE, 0);
    execute(2'b10, '0, 32'h0FC);
    fetch(32'h0000_0000, 1);
    execute(2'b01, 32'h100, 32'h100);
    fetch(32'h0000_0003, 1);
    execute(2'b10, '0, 32'h110);
    fetch(32'h0000_0000, 1);

    // Jump and jr
    execute(2'b01, 32'h9000_0010, 32'h9000_0010);
    fetch(32'h0800_0040, 1);
    execute(2'b11, '0, 32'h9000_0100);
    fetch(32'h0000_0000, 1);
    execute(2'b01, 32'h0000_2000, 32'h0000_2000);
    fetch(32'hCAFE_0001, 1);

    // Stray ack in EXEC
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack   = 1'b0;
    chk("stray_inst", inst, last_inst);
    chk("stray_pc", pc, 32'h2000);
    chk("stray_valid", 32'(inst_valid), 32'd1);

    // PC wrap
    execute(2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0);
    execute(2'b00, '0, 32'h0);

    // Reset while a fetch is outstanding, late ack during BOOT
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_inst", inst, 32'h0);
    exp_addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("boot2_req", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack   = 1'b0;
    chk("late_ack_inst", inst, 32'h0);
    chk("post_boot_req", 32'(imem_req), 32'd1);
    chk("post_boot_addr", imem_addr, 32'h0);

    // inst_ready while fetching is ignored
    PC_s       = 2'b01;
    rs_data    = 32'h3000;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("ready_in_fetch_pc", pc, 32'h0);
    exp_addr_q.push_back(32'h0);
    fetch(32'h4444_0000, 1);

    // Misaligned jr target
    PC_s       = 2'b01;
    rs_data    = 32'h0000_2002;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("trap_align", 32'(align_err), 32'd1);
    chk("trap_pc", pc, 32'h0);
    chk("trap_valid", 32'(inst_valid), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_hold", 32'(align_err), 32'd1);
      @(negedge clk);
    end
`else
    chk("noalign_err", 32'(align_err), 32'd0);
    chk("noalign_pc", pc, 32'h2000);
    exp_addr_q.push_back(32'h2000);
    fetch(32'h5555_0000, 1);
    chk("noalign_err2", 32'(align_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
